window3x3_gen: RTL

- Downstream consumer of the 640-entry 8-bit pixel line FIFO on the D8M loopback path.
- Takes the grayscale pixel stream drained from the FIFO and builds a sliding 3x3 neighbourhood.
- Uses two internal line stores and column/row counters to do this.
- Emits one registered 72-bit window per interior pixel, with centre coordinates, to the filter stage (Sobel/blur).

---
 rtl/win_pkg.sv | 12 +
 rtl/window3x3_gen_line_store.sv | 23 ++
 rtl/window3x3_gen.sv | 138 +++++++++++++
 3 files changed

// File: rtl/win_pkg.sv
// Shared constants and types for the 3x3 window generator.
// PIX_W_DEF/CW_DEF/IMG_*_DEF are the defaults the top-level parameters pick up.
package win_pkg;
    localparam int PIX_W_DEF = 8;
    localparam int CW_DEF    = 10;
    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;
    localparam int WIN_N     = 9;

    // Index 8 is w00 (oldest row, oldest column); index 0 is w22 (current pixel).
    typedef logic [WIN_N-1:0][PIX_W_DEF-1:0] win_t;
endpackage

// File: rtl/window3x3_gen_line_store.sv
// Single-port line RAM.
// The read is asynchronous, so a read and a write to the same address in one cycle return the old value.
module line_store #(
    parameter int DEPTH = 640,
    parameter int W     = 8,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wr_data,
    output logic [W-1:0]  rd_data
);
    logic [W-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end
endmodule

// File: rtl/window3x3_gen.sv
// Sliding 3x3 neighbourhood generator over a raster pixel stream, one window per interior pixel.
// Optional WIN_LINE_CHK_EN adds a sticky err_line flag for short/truncated frames.
module window3x3_gen
    import win_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int PIX_W = PIX_W_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PIX_W-1:0]       pix_in,
    input  logic                   pix_valid,
    input  logic                   sof,
    output logic [WIN_N*PIX_W-1:0] win_data,
    output logic                   win_valid,
    output logic [CW-1:0]          win_row,
    output logic [CW-1:0]          win_col,
`ifdef WIN_LINE_CHK_EN
    output logic                   err_line,
`endif
    output logic                   eof_out
);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);

    logic [CW-1:0] col_q, col_d, row_q, row_d;
    logic [CW-1:0] cur_col, cur_row;
    logic [PIX_W-1:0] top_pix, mid_pix;
    logic [WIN_N-1:0][PIX_W-1:0] win_q, win_d;
    logic win_valid_q, win_valid_d;
    logic eof_q, eof_d;
    logic [CW-1:0] win_row_q, win_row_d, win_col_q, win_col_d;
    logic at_last;

    // sof overrides the counters, so the accepted pixel is (0,0) in the same cycle.
    assign cur_col = sof ? '0 : col_q;
    assign cur_row = sof ? '0 : row_q;
    assign at_last = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

    line_store #(.DEPTH(IMG_W), .W(PIX_W), .AW(CW)) u_lb0 (
        .clk     (clk),
        .we      (pix_valid),
        .addr    (cur_col),
        .wr_data (pix_in),
        .rd_data (mid_pix)
    );

    line_store #(.DEPTH(IMG_W), .W(PIX_W), .AW(CW)) u_lb1 (
        .clk     (clk),
        .we      (pix_valid),
        .addr    (cur_col),
        .wr_data (mid_pix),
        .rd_data (top_pix)
    );

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        win_valid_d = 1'b0;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        eof_d       = 1'b0;
        if (pix_valid) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + CW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
            // Each window row shifts one column left; the new column enters on the right.
            win_d[8:7]  = win_q[7:6];
            win_d[5:4]  = win_q[4:3];
            win_d[2:1]  = win_q[1:0];
            win_d[6]    = top_pix;
            win_d[3]    = mid_pix;
            win_d[0]    = pix_in;
            win_valid_d = (cur_row >= CW'(2)) && (cur_col >= CW'(2));
            win_row_d   = cur_row - CW'(1);
            win_col_d   = cur_col - CW'(1);
            eof_d       = at_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            eof_q       <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            eof_q       <= eof_d;
        end
    end

    assign win_data  = win_q;
    assign win_valid = win_valid_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
    assign eof_out   = eof_q;

`ifdef WIN_LINE_CHK_EN
    logic err_q, err_d, last_q, last_d;

    // last_q remembers whether the most recent accept closed a frame.
    always_comb begin
        last_d = pix_valid ? at_last : last_q;
        err_d  = err_q;
        if (pix_valid && sof && ((row_q != '0) || (col_q != '0)) && !last_q) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            err_q  <= err_d;
            last_q <= last_d;
        end
    end

    assign err_line = err_q;
`endif
endmodule
